// File: rtl/spike_latency_encoder_if.sv
// spike_latency_encoder_if: start/pixel/spike bundle for spike_latency_encoder.
// i_abort is present only when ENC_ABORT_EN is defined.
interface spike_latency_encoder_if #(
    parameter int p_width = 8
);
    logic               i_start;
    logic [p_width-1:0] i_pixel_1;
    logic [p_width-1:0] i_pixel_2;
    logic [p_width-1:0] i_pixel_3;
    logic [p_width-1:0] i_pixel_4;
    logic [p_width-1:0] i_pixel_5;
    logic [p_width-1:0] i_pixel_6;
    logic [p_width-1:0] i_pixel_7;
    logic [p_width-1:0] i_pixel_8;
`ifdef ENC_ABORT_EN
    logic               i_abort;
`endif
    logic [8:1]         o_event;
    logic               o_busy;
    logic               o_done;
`ifdef ENC_ABORT_EN
    modport master (
        output i_start, i_pixel_1, i_pixel_2, i_pixel_3, i_pixel_4,
               i_pixel_5, i_pixel_6, i_pixel_7, i_pixel_8, i_abort,
        input  o_event, o_busy, o_done
    );
    modport slave (
        input  i_start, i_pixel_1, i_pixel_2, i_pixel_3, i_pixel_4,
               i_pixel_5, i_pixel_6, i_pixel_7, i_pixel_8, i_abort,
        output o_event, o_busy, o_done
    );
`else
    modport master (
        output i_start, i_pixel_1, i_pixel_2, i_pixel_3, i_pixel_4,
               i_pixel_5, i_pixel_6, i_pixel_7, i_pixel_8,
        input  o_event, o_busy, o_done
    );
    modport slave (
        input  i_start, i_pixel_1, i_pixel_2, i_pixel_3, i_pixel_4,
               i_pixel_5, i_pixel_6, i_pixel_7, i_pixel_8,
        output o_event, o_busy, o_done
    );
`endif
endinterface

// File: rtl/spike_latency_encoder.sv
// spike_latency_encoder: 8-channel time-to-first-spike encoder, brighter pixels fire earlier.
// Define ENC_ABORT_EN to add i_abort, which cancels a running window.
module spike_latency_encoder #(
    parameter int p_width = 8,
    parameter int p_div   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    spike_latency_encoder_if.slave bus
);
    localparam int dw = (p_div > 1) ? $clog2(p_div) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [p_width-1:0] pix_in [1:8];
    logic [p_width-1:0] pix_q  [1:8];
    logic [1:0]         state_q, state_d;
    logic [p_width-1:0] t_q, t_d;
    logic [dw-1:0]      d_q, d_d;
    logic [8:1]         event_q, event_d, fire;
    logic               start, tick, last, abort;

    assign pix_in[1] = bus.i_pixel_1;
    assign pix_in[2] = bus.i_pixel_2;
    assign pix_in[3] = bus.i_pixel_3;
    assign pix_in[4] = bus.i_pixel_4;
    assign pix_in[5] = bus.i_pixel_5;
    assign pix_in[6] = bus.i_pixel_6;
    assign pix_in[7] = bus.i_pixel_7;
    assign pix_in[8] = bus.i_pixel_8;

`ifdef ENC_ABORT_EN
    assign abort = bus.i_abort && state_q == S_RUN;
`else
    assign abort = 1'b0;
`endif

    // (2^w-1) - v is simply ~v in w bits
    for (genvar k = 1; k <= 8; k++) begin : g_ch
        assign fire[k] = (pix_q[k] != '0) && (t_q == ~pix_q[k]);
    end

    always_comb begin
        start   = state_q == S_IDLE && bus.i_start;
        tick    = state_q == S_RUN && d_q == dw'(p_div - 1);
        last    = tick && (&t_q);
        state_d = start ? S_RUN :
                  state_q == S_RUN ? (abort ? S_IDLE : last ? S_DONE : S_RUN) : S_IDLE;
        d_d     = (state_q != S_RUN || tick) ? '0 : d_q + dw'(1);
        t_d     = start ? '0 : tick ? t_q + p_width'(1) : t_q;
        event_d = (tick && !abort) ? fire : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            d_q     <= '0;
            event_q <= '0;
            for (int i = 1; i <= 8; i++) pix_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            d_q     <= d_d;
            event_q <= event_d;
            if (start) for (int i = 1; i <= 8; i++) pix_q[i] <= pix_in[i];
        end
    end

    assign bus.o_event = event_q;
    assign bus.o_busy  = state_q == S_RUN;
    assign bus.o_done  = state_q == S_DONE;
endmodule

// File: tb/tb_spike_latency_encoder.sv
// tb_spike_latency_encoder: directed checks for spike_latency_encoder (p_div=1 and p_div=4).
module tb_spike_latency_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spike_latency_encoder_if #(.p_width(8)) a_if ();
    spike_latency_encoder_if #(.p_width(8)) b_if ();

    spike_latency_encoder #(.p_width(8), .p_div(1)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a_if));
    spike_latency_encoder #(.p_width(8), .p_div(4)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b_if));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_pix(input logic [63:0] v);
        {a_if.i_pixel_8, a_if.i_pixel_7, a_if.i_pixel_6, a_if.i_pixel_5,
         a_if.i_pixel_4, a_if.i_pixel_3, a_if.i_pixel_2, a_if.i_pixel_1} = v;
    endtask

    task automatic b_pix(input logic [63:0] v);
        {b_if.i_pixel_8, b_if.i_pixel_7, b_if.i_pixel_6, b_if.i_pixel_5,
         b_if.i_pixel_4, b_if.i_pixel_3, b_if.i_pixel_2, b_if.i_pixel_1} = v;
    endtask

    initial begin
        int dcnt, bcnt, r1, r2, nrise, dedge, spur;
        logic prev;
        logic [7:0] ev;
        a_if.i_start = 1'b0;
        b_if.i_start = 1'b0;
        a_pix('0);
        b_pix('0);
`ifdef ENC_ABORT_EN
        a_if.i_abort = 1'b0;
        b_if.i_abort = 1'b0;
`endif
        #2;
        chk("rst_event", a_if.o_event, 8'h00);
        chk("rst_busy", a_if.o_busy, 0);
        chk("rst_done", a_if.o_done, 0);
        #20 rst_n = 1'b1;
        step();
        step();

        // mixed pixels, restart attempt with new pixels at E10 must be ignored
        a_pix(64'h00_40_ff_00_01_80_fe_ff);
        a_if.i_start = 1'b1;
        step();
        a_if.i_start = 1'b0;
        chk("w1_busy_e0", a_if.o_busy, 1);
        for (int n = 1; n <= 257; n++) begin
            step();
            ev = n == 1 ? 8'h21 : n == 2 ? 8'h02 : n == 128 ? 8'h04 :
                 n == 192 ? 8'h40 : n == 255 ? 8'h08 : 8'h00;
            chk($sformatf("w1_event_e%0d", n), a_if.o_event, ev);
            chk($sformatf("w1_busy_e%0d", n), a_if.o_busy, n < 256);
            chk($sformatf("w1_done_e%0d", n), a_if.o_done, n == 256);
            if (n == 9) begin
                a_if.i_start = 1'b1;
                a_pix({8{8'h10}});
            end
            if (n == 10) a_if.i_start = 1'b0;
        end

        // reset in the middle of a window, right after a spike
        a_pix(64'h00_00_00_00_00_00_00_ce);
        a_if.i_start = 1'b1;
        step();
        a_if.i_start = 1'b0;
        repeat (50) step();
        chk("rst_mid_event_pre", a_if.o_event, 8'h01);
        chk("rst_mid_busy_pre", a_if.o_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_event", a_if.o_event, 8'h00);
        chk("rst_mid_busy", a_if.o_busy, 0);
        chk("rst_mid_done", a_if.o_done, 0);
        #3 rst_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            dcnt += int'(a_if.o_done);
            bcnt += int'(a_if.o_busy);
        end
        chk("rst_mid_no_done", dcnt, 0);
        chk("rst_mid_no_busy", bcnt, 0);

        // start held high: windows every 258 cycles
        a_pix({8{8'h80}});
        a_if.i_start = 1'b1;
        step();
        prev = a_if.o_busy;
        dcnt = 0;
        nrise = 0;
        r1 = 0;
        r2 = 0;
        for (int n = 1; n <= 774; n++) begin
            step();
            dcnt += int'(a_if.o_done);
            if (a_if.o_busy && !prev) begin
                nrise++;
                if (nrise == 1) r1 = n;
                if (nrise == 2) r2 = n;
            end
            prev = a_if.o_busy;
        end
        a_if.i_start = 1'b0;
        chk("b2b_rise1", r1, 258);
        chk("b2b_rise2", r2, 516);
        chk("b2b_done_cnt", dcnt, 3);
        repeat (260) step();
        chk("b2b_idle", a_if.o_busy, 0);

        // p_div=4, all ff
        b_pix({8{8'hff}});
        b_if.i_start = 1'b1;
        step();
        b_if.i_start = 1'b0;
        bcnt = int'(b_if.o_busy);
        dcnt = 0;
        dedge = 0;
        for (int n = 1; n <= 1030; n++) begin
            step();
            if (n <= 6) chk($sformatf("div4_event_e%0d", n), b_if.o_event, n == 4 ? 8'hff : 8'h00);
            bcnt += int'(b_if.o_busy);
            if (b_if.o_done) begin
                dcnt++;
                dedge = n;
            end
        end
        chk("div4_busy_cycles", bcnt, 1024);
        chk("div4_done_edge", dedge, 1024);
        chk("div4_done_cnt", dcnt, 1);

`ifdef ENC_ABORT_EN
        a_pix(64'h80_80_80_80_80_80_80_ff);
        a_if.i_start = 1'b1;
        step();
        a_if.i_start = 1'b0;
        spur = 0;
        dcnt = 0;
        for (int n = 1; n <= 140; n++) begin
            step();
            if (n == 1) chk("abort_event_e1", a_if.o_event, 8'h01);
            else spur += int'(a_if.o_event != 8'h00);
            if (n == 50) chk("abort_busy_e50", a_if.o_busy, 0);
            dcnt += int'(a_if.o_done);
            if (n == 49) a_if.i_abort = 1'b1;
            if (n == 50) a_if.i_abort = 1'b0;
        end
        chk("abort_no_spikes", spur, 0);
        chk("abort_no_done", dcnt, 0);
        a_if.i_start = 1'b1;
        step();
        a_if.i_start = 1'b0;
        for (int n = 1; n <= 257; n++) begin
            step();
            if (n == 1) chk("abort_next_e1", a_if.o_event, 8'h01);
            if (n == 128) chk("abort_next_e128", a_if.o_event, 8'hfe);
            if (n == 256) chk("abort_next_done", a_if.o_done, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_latency_encoder.md
SPIKE_LATENCY_ENCODER -- requirements
Module: spike_latency_encoder

Interface
REQ-001 Parameter p_width, default 8: intensity width in bits; encoding window is 2^p_width ticks.
REQ-002 Parameter p_div, default 1, minimum 1: clock cycles per tick (time-step prescaler).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  request one encoding window; sampled only in IDLE.
REQ-006 i_pixel_1 .. i_pixel_8  input  p_width each  channel intensities, unsigned; latched at accepted start.
REQ-007 o_event  output  [8:1]  one-cycle spike per channel; bit k drives neuron_8s i_event[k] directly.
REQ-008 o_busy  output  1  high while in RUN.
REQ-009 o_done  output  1  one-cycle pulse at window end.

Function
REQ-010 States: IDLE, RUN, DONE; the block SHALL use only these three (plus none other).
REQ-011 IDLE: at the edge where i_start=1, latch all eight pixels, clear tick counter t and prescale counter d, go to RUN.
REQ-012 RUN: d increments each cycle; a tick occurs at an edge where d = p_div-1, then d wraps to 0.
REQ-013 On each tick: o_event[k] <= 1 iff t = (2^p_width-1) - pixel_k and pixel_k != 0; t <= t+1.
REQ-014 o_event SHALL be 0 on every cycle not directly following a firing tick; each channel fires at most once per window.
REQ-015 Latency: with p_div=1, start accepted at edge E0, pixel 2^p_width-1 spikes visible after E1; pixel v spikes after edge E(p_div*(2^p_width-v)).
REQ-016 Pixel 0 SHALL never spike; all equal pixels spike in the same cycle.
REQ-017 Tick with t = 2^p_width-1 is the last: state <= DONE; t does not wrap into a new window.
REQ-018 DONE lasts exactly one cycle with o_done=1, then IDLE; i_start during DONE is ignored.
REQ-019 i_start during RUN or DONE SHALL be ignored (no restart, no relatch); pixel input changes during RUN have no effect.
REQ-020 o_busy = 1 exactly in RUN; o_busy and o_done never both high.
REQ-021 Back-to-back: i_start held high from DONE onward is accepted in the first IDLE cycle; minimum start-to-start period is p_div*2^p_width + 2 cycles.

Reset
REQ-022 i_rst_n low SHALL immediately force IDLE, t=0, d=0, latched pixels=0, o_event=0, o_busy=0, o_done=0.
REQ-023 Reset mid-RUN SHALL abandon the window without o_done; after release the block waits for a new i_start.

Configuration
REQ-024 Macro ENC_ABORT_EN: when defined, an input port i_abort (1 bit) exists; i_abort=1 at an edge in RUN forces IDLE, o_event=0 next cycle, no o_done; i_abort takes priority over a simultaneous tick.
REQ-025 Without ENC_ABORT_EN: no i_abort port; a window always runs to completion unless reset.

Verification
REQ-026 Reset: assert i_rst_n=0 mid-window with any pixels -> all outputs 0 asynchronously, no o_done after release.
REQ-027 p_div=1, pixels 1:ff 2:fe 3:80 4:01 5:00 6:ff 7:40 8:00, start -> o_event 8'b00100001 after E1, bit2 after E2, bit3 after E128, bit7 after E192, bit4 after E255, bits5/8 never; o_done high after E256 for one cycle.
REQ-028 p_div=4, all pixels ff -> o_event=8'hff one cycle after edge E4; o_busy high 1024 cycles; o_done after E1024.
REQ-029 Pulse i_start again at E10 of a running window and change pixels -> no restart, spike times unchanged from first latch.
REQ-030 Hold i_start=1 continuously, p_div=1 -> windows start every 258 cycles, o_done exactly once per window.
REQ-031 ENC_ABORT_EN defined: i_abort=1 at E50 with pixel ff... all 80 -> o_busy low after E50, no spikes at E128, no o_done; next start encodes normally.
